fd_pipe_reg: RTL

Parametrised elastic fetch→decode pipeline register for the pipelined RISC-V core. It replaces the plain always-latching IF/ID register with a DEPTH-entry in-order buffer. The buffer carries {instruction, PC, PC+4} and uses a valid/ready handshake, so back-pressure from decode/hazard logic stalls fetch without losing instructions. Flush (taken branch/jump) discards all buffered entries, and a NOP is presented whenever nothing valid is held.

---
 rtl/fd_pipe_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: elastic IF/ID pipeline register.
// Holds up to DEPTH fetched {instruction, PC, PC+4} entries in a circular
// buffer with a valid/ready handshake on both sides. A flush from a taken
// branch/jump empties the buffer. A NOP is presented to decode whenever no
// valid entry is held.
module fd_pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           InstrF,
    input  logic [WIDTH-1:0]           PCF,
    input  logic [WIDTH-1:0]           PCPlus4F,
    input  logic                       flush_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           InstrD,
    output logic [WIDTH-1:0]           PCD,
    output logic [WIDTH-1:0]           PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Pointer advance with wrap from DEPTH-1 back to 0 (DEPTH need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PTR_LAST) begin
            n = PTR_ZERO;
        end else begin
            n = p + PTR_ONE;
        end
        return n;
    endfunction

    logic [WIDTH-1:0] r_instr [0:DEPTH-1];
    logic [WIDTH-1:0] r_pc    [0:DEPTH-1];
    logic [WIDTH-1:0] r_pc4   [0:DEPTH-1];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Handshake flags depend on occupancy only, so ready_o has no path from
    // ready_i/valid_i; a flush cancels both transfers in its cycle.
    assign w_ready = (r_count < CNT_FULL);
    assign w_valid = (r_count != CNT_ZERO);
    assign w_push  = valid_i & w_ready & ~flush_i;
    assign w_pop   = w_valid & ready_i & ~flush_i;

    // Entry storage: written at the write pointer on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= InstrF;
            r_pc[r_wr_ptr]    <= PCF;
            r_pc4[r_wr_ptr]   <= PCPlus4F;
        end
    end

    // Pointer and occupancy bookkeeping; flush returns the buffer to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else if (flush_i) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Decode-side view: head entry when valid, otherwise a NOP with zero PCs.
    always_comb begin
        InstrD   = NOP_INSTR;
        PCD      = {WIDTH{1'b0}};
        PCPlus4D = {WIDTH{1'b0}};
        if (w_valid) begin
            InstrD   = r_instr[r_rd_ptr];
            PCD      = r_pc[r_rd_ptr];
            PCPlus4D = r_pc4[r_rd_ptr];
        end else begin
            InstrD   = NOP_INSTR;
            PCD      = {WIDTH{1'b0}};
            PCPlus4D = {WIDTH{1'b0}};
        end
    end

    assign ready_o = w_ready;
    assign valid_o = w_valid;
    assign count_o = r_count;

endmodule
